// File: rtl/label_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : label_display_ctrl
//  Purpose  : Grants the single text-overlay layer to one of NUM_LABELS label
//             renderers by fixed priority (index 0 highest), shows the label
//             steady for SHOW_FRAMES frames, blinks it for BLINK_FRAMES frames
//             (BLINK_PERIOD frames per visible/hidden half), then releases.
//             The granted renderer's per-pixel bit is gated into a registered
//             overlay_on for the color mapper.
//  Ports    : Clk          - system clock
//             Reset        - synchronous active-high reset
//             DrawX/DrawY  - current pixel column/row from the VGA controller
//             show_req     - level request per label, held until acked
//             label_on     - per-pixel on bit from each label renderer
//             req_ack      - one-cycle one-hot grant pulse
//             active_label - index of the granted label
//             busy         - high while a label is showing or blinking
//             overlay_on   - pixel enable, one Clk after DrawX/DrawY
//  Revision : 1.0 - initial release
// ============================================================================
module label_display_ctrl #(
   parameter int NUM_LABELS   = 4,
   parameter int SHOW_FRAMES  = 120,
   parameter int BLINK_FRAMES = 60,
   parameter int BLINK_PERIOD = 8,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   localparam int LW = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic [NUM_LABELS-1:0] show_req,
   input  logic [NUM_LABELS-1:0] label_on,
   output logic [NUM_LABELS-1:0] req_ack,
   output logic [LW-1:0]         active_label,
   output logic                  busy,
   output logic                  overlay_on
);

   localparam int FMAX = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);
   localparam int BW   = $clog2(BLINK_PERIOD + 1);

   localparam logic [9:0]    c_H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]    c_V_ACT  = 10'(V_ACTIVE);
   localparam logic [FW-1:0] c_SHOW   = FW'(SHOW_FRAMES);
   localparam logic [FW-1:0] c_BLINKF = FW'(BLINK_FRAMES);
   localparam logic [BW-1:0] c_PERIOD = BW'(BLINK_PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLINK = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [FW-1:0]         r_frame_cnt;
   logic [FW-1:0]         w_frame_nxt;
   logic [BW-1:0]         r_blink_cnt;
   logic [BW-1:0]         w_blink_nxt;
   logic                  r_visible;
   logic                  w_visible_nxt;
   logic [LW-1:0]         r_active_label;
   logic [LW-1:0]         w_label_nxt;
   logic [NUM_LABELS-1:0] r_req_ack;
   logic [NUM_LABELS-1:0] w_ack_nxt;
   logic                  r_busy;
   logic                  r_overlay_on;
   logic                  r_cond_q;

   logic                  w_cond;
   logic                  w_tick;
   logic                  w_any;
   logic [LW-1:0]         w_win;
   logic                  w_grant;
   logic                  w_in_area;

   // Frame tick: rising edge of the "first pixel past the last active line"
   // condition, so a DrawX held for several Clk cycles still ticks once.
   assign w_cond    = (DrawX == 10'd0) && (DrawY == c_V_ACT);
   assign w_tick    = w_cond && !r_cond_q;
   assign w_any     = |show_req;
   assign w_in_area = (DrawX < c_H_ACT) && (DrawY < c_V_ACT);

   // Lowest set index wins; scanning downward leaves the lowest one last.
   always_comb begin
      w_win = '0;
      for (int i = NUM_LABELS - 1; i >= 0; i--) begin
         if (show_req[i]) begin
            w_win = LW'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_frame_nxt   = r_frame_cnt;
      w_blink_nxt   = r_blink_cnt;
      w_visible_nxt = r_visible;
      w_label_nxt   = r_active_label;
      w_ack_nxt     = '0;
      // While busy only an equal or higher priority requester may restart.
      w_grant       = w_any && ((r_state == ST_IDLE) || (w_win <= r_active_label));

      if (w_grant) begin
         // A grant overrides a coincident frame tick.
         w_label_nxt   = w_win;
         w_ack_nxt     = NUM_LABELS'(1) << w_win;
         w_frame_nxt   = c_SHOW;
         w_visible_nxt = 1'b1;
         w_state_nxt   = ST_SHOW;
      end else if (w_tick) begin
         case (r_state)
            ST_SHOW: begin
               if (r_frame_cnt == FW'(1)) begin
                  w_frame_nxt   = c_BLINKF;
                  w_blink_nxt   = c_PERIOD;
                  w_visible_nxt = 1'b1;
                  w_state_nxt   = ST_BLINK;
               end else begin
                  w_frame_nxt = r_frame_cnt - FW'(1);
               end
            end
            ST_BLINK: begin
               if (r_frame_cnt == FW'(1)) begin
                  w_visible_nxt = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_frame_nxt = r_frame_cnt - FW'(1);
                  if (r_blink_cnt == BW'(1)) begin
                     w_visible_nxt = ~r_visible;
                     w_blink_nxt   = c_PERIOD;
                  end else begin
                     w_blink_nxt = r_blink_cnt - BW'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_frame_cnt    <= '0;
         r_blink_cnt    <= '0;
         r_visible      <= 1'b1;
         r_active_label <= '0;
         r_req_ack      <= '0;
         r_busy         <= 1'b0;
         r_overlay_on   <= 1'b0;
         r_cond_q       <= 1'b0;
      end else begin
         r_frame_cnt    <= w_frame_nxt;
         r_blink_cnt    <= w_blink_nxt;
         r_visible      <= w_visible_nxt;
         r_active_label <= w_label_nxt;
         r_req_ack      <= w_ack_nxt;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_cond_q       <= w_cond;
         // Uses the pre-edge grant so the pixel matches the label on screen.
         r_overlay_on   <= r_busy && r_visible && label_on[r_active_label] && w_in_area;
      end
   end

   assign req_ack      = r_req_ack;
   assign active_label = r_active_label;
   assign busy         = r_busy;
   assign overlay_on   = r_overlay_on;

endmodule
`default_nettype wire
